// File: rtl/pe_irq_pkg.sv
// -----------------------------------------------------------------------------
// pe_irq_pkg
// Shared types, register offsets and helpers for the PE interrupt controller.
//   IRQ_MAX    : widest supported source vector (controller NUM_IRQ is 1..IRQ_MAX)
//   irq_vec_t  : source/pending vector at maximum width
//   REG_*      : byte offsets of the registers from the block base address
//   ID_NONE    : ID register value when no cause bit is set
//   prio_enc() : index of the lowest set bit, or ID_NONE
// -----------------------------------------------------------------------------
package pe_irq_pkg;

    localparam int unsigned IRQ_MAX = 8;

    typedef logic [IRQ_MAX-1:0] irq_vec_t;

    localparam logic [7:0] REG_CAUSE  = 8'h00;
    localparam logic [7:0] REG_MASK   = 8'h10;
    localparam logic [7:0] REG_STATUS = 8'h20;
    localparam logic [7:0] REG_EDGE   = 8'h30;
    localparam logic [7:0] REG_ACK    = 8'h40;
    localparam logic [7:0] REG_ID     = 8'h50;
    localparam logic [7:0] REG_CNT    = 8'h60;
    localparam logic [7:0] REG_CMP    = 8'h70;

    localparam logic [7:0] ID_NONE = 8'hFF;

    // Walk from the top down so the lowest set index is the last one written.
    function automatic logic [7:0] prio_enc(input irq_vec_t vec);
        logic [7:0] id;
        id = ID_NONE;
        for (int i = IRQ_MAX - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = 8'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/pe_irq_edge_cell.sv
// -----------------------------------------------------------------------------
// pe_irq_edge_cell
// One interrupt source: previous-value flop for rising-edge detection plus the
// sticky pending bit.
//   clock        : system clock
//   reset        : asynchronous active-low reset
//   i_src        : source level, synchronous to clock
//   i_edge_mode  : 1 = rising-edge mode (sticky until ACK), 0 = level mode
//   i_ack        : acknowledge strobe for this bit (edge mode only)
//   o_pending    : registered pending bit
// -----------------------------------------------------------------------------
module pe_irq_edge_cell (
    input  logic clock,
    input  logic reset,
    input  logic i_src,
    input  logic i_edge_mode,
    input  logic i_ack,
    output logic o_pending
);

    logic r_prev;
    logic r_pending;
    logic w_rise;
    logic w_pending_d;

    // prev resets to 0, so a source already high at reset release yields one edge.
    assign w_rise = i_src & ~r_prev;

    always_comb begin
        w_pending_d = i_src;
        if (i_edge_mode) begin
            // Set wins over a same-cycle acknowledge.
            w_pending_d = (r_pending & ~i_ack) | w_rise;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_prev    <= i_src;
            r_pending <= w_pending_d;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/pe_irq_ctrl.sv
// -----------------------------------------------------------------------------
// pe_irq_ctrl
// MMIO interrupt controller for one manycore PE, mapped in the INTERNAL region.
// Adds per-source edge/level mode, masking, sticky pending, acknowledge and a
// priority-encoded ID in front of the core's extio_in.
//
// Optional build macro PE_IRQ_TIMER_EN: adds a free-running 32-bit cycle
// counter (0x60, RO) and a compare register (0x70, RW, reset all-ones). A match
// pulses source NUM_IRQ-1, which is then locked into edge mode.
//
// Ports:
//   clock        : system clock
//   reset        : asynchronous active-low reset
//   irq_src_in   : raw interrupt sources, synchronous to clock
//   sel_in       : access targets the INTERNAL region
//   addr_in      : CPU address, bits [1:0] ignored
//   wr_in        : write strobe
//   data_in      : write data (bits above NUM_IRQ ignored for vector registers)
//   data_out     : read data, registered (valid the cycle after the address)
//   irq_out      : registered (pending & mask)
//   irq_any_out  : OR of irq_out
// -----------------------------------------------------------------------------
module pe_irq_ctrl
    import pe_irq_pkg::*;
#(
    parameter int unsigned               MEMORY_WIDTH = 32,
    parameter int unsigned               NUM_IRQ      = 8,
    parameter logic [MEMORY_WIDTH-1:0]   BASE_ADDR    = 'hF0000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_IRQ-1:0]      irq_src_in,
    input  logic                    sel_in,
    input  logic [MEMORY_WIDTH-1:0] addr_in,
    input  logic                    wr_in,
    input  logic [MEMORY_WIDTH-1:0] data_in,
    output logic [MEMORY_WIDTH-1:0] data_out,
    output logic [NUM_IRQ-1:0]      irq_out,
    output logic                    irq_any_out
);

    // ------------------------------------------------------------------
    // Address decode: the block spans 256 bytes at BASE_ADDR.
    // ------------------------------------------------------------------
    logic       w_hit;
    logic       w_wr;
    logic [7:0] w_off;

    assign w_hit = sel_in && (addr_in[MEMORY_WIDTH-1:8] == BASE_ADDR[MEMORY_WIDTH-1:8]);
    assign w_off = {addr_in[7:2], 2'b00};
    assign w_wr  = w_hit && wr_in;

    logic w_unused;
    assign w_unused = ^{addr_in[1:0], data_in[MEMORY_WIDTH-1:NUM_IRQ]};

    // ------------------------------------------------------------------
    // Control registers and per-source vectors
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0]      r_mask;
    logic [NUM_IRQ-1:0]      r_edge;
    logic [NUM_IRQ-1:0]      r_irq;
    logic [MEMORY_WIDTH-1:0] r_data_out;

    logic [NUM_IRQ-1:0]      w_src;
    logic [NUM_IRQ-1:0]      w_edge_eff;
    logic [NUM_IRQ-1:0]      w_ack;
    logic [NUM_IRQ-1:0]      w_pending;
    logic [NUM_IRQ-1:0]      w_cause;
    irq_vec_t                w_cause_ext;
    logic [7:0]              w_id;
    logic [MEMORY_WIDTH-1:0] w_rdata;

    assign w_ack = (w_wr && (w_off == REG_ACK)) ? data_in[NUM_IRQ-1:0] : '0;

`ifdef PE_IRQ_TIMER_EN
    // ------------------------------------------------------------------
    // Timer: compare match pulses the top source for exactly one cycle per
    // counter wrap; rewriting compare simply moves the next match point.
    // ------------------------------------------------------------------
    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        w_match;
    logic        w_unused_edge;

    assign w_match       = (r_count == r_cmp);
    assign w_unused_edge = r_edge[NUM_IRQ-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_cmp   <= '1;
        end else begin
            r_count <= r_count + 32'd1;
            if (w_wr && (w_off == REG_CMP)) begin
                r_cmp <= data_in[31:0];
            end
        end
    end

    always_comb begin
        w_src                   = irq_src_in;
        w_src[NUM_IRQ-1]        = irq_src_in[NUM_IRQ-1] | w_match;
        w_edge_eff              = r_edge;
        w_edge_eff[NUM_IRQ-1]   = 1'b1;
    end
`else
    assign w_src      = irq_src_in;
    assign w_edge_eff = r_edge;
`endif

    // ------------------------------------------------------------------
    // Per-source edge/level pending cells
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_cell
        pe_irq_edge_cell u_cell (
            .clock       (clock),
            .reset       (reset),
            .i_src       (w_src[g]),
            .i_edge_mode (w_edge_eff[g]),
            .i_ack       (w_ack[g]),
            .o_pending   (w_pending[g])
        );
    end

    // Masked sources keep latching; they only surface in CAUSE once unmasked.
    assign w_cause = w_pending & r_mask;

    always_comb begin
        w_cause_ext                = '0;
        w_cause_ext[NUM_IRQ-1:0]   = w_cause;
    end

    assign w_id = prio_enc(w_cause_ext);

    // ------------------------------------------------------------------
    // Read mux (registered below for one-cycle read latency)
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_off)
                REG_CAUSE:  w_rdata[NUM_IRQ-1:0] = w_cause;
                REG_MASK:   w_rdata[NUM_IRQ-1:0] = r_mask;
                REG_STATUS: w_rdata[NUM_IRQ-1:0] = irq_src_in;
                REG_EDGE:   w_rdata[NUM_IRQ-1:0] = w_edge_eff;
                REG_ID:     w_rdata[7:0]         = w_id;
`ifdef PE_IRQ_TIMER_EN
                REG_CNT:    w_rdata[31:0]        = r_count;
                REG_CMP:    w_rdata[31:0]        = r_cmp;
`else
                REG_CNT, REG_CMP: w_rdata        = '0;
`endif
                default:    w_rdata              = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mask     <= '0;
            r_edge     <= '0;
            r_irq      <= '0;
            r_data_out <= '0;
        end else begin
            r_data_out <= w_rdata;
            r_irq      <= w_cause;
            if (w_wr && (w_off == REG_MASK)) begin
                r_mask <= data_in[NUM_IRQ-1:0];
            end
            if (w_wr && (w_off == REG_EDGE)) begin
                r_edge <= data_in[NUM_IRQ-1:0];
            end
        end
    end

    assign data_out    = r_data_out;
    assign irq_out     = r_irq;
    assign irq_any_out = |r_irq;

endmodule

// File: tb/tb_pe_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_irq_ctrl
// Self-checking bench for pe_irq_ctrl: a hand-derived vector table, an
// asynchronous reset sequence, then randomized traffic against a behavioural
// model of the register map and interrupt rules.
// -----------------------------------------------------------------------------
module tb_pe_irq_ctrl;

    localparam logic [31:0] BASE = 32'hF0000000;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  irq_src_in;
    logic        sel_in;
    logic [31:0] addr_in;
    logic        wr_in;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [7:0]  irq_out;
    logic        irq_any_out;

    pe_irq_ctrl #(
        .MEMORY_WIDTH (32),
        .NUM_IRQ      (8),
        .BASE_ADDR    (BASE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .irq_src_in  (irq_src_in),
        .sel_in      (sel_in),
        .addr_in     (addr_in),
        .wr_in       (wr_in),
        .data_in     (data_in),
        .data_out    (data_out),
        .irq_out     (irq_out),
        .irq_any_out (irq_any_out)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: per-bit rules applied at each rising clock edge.
    // ------------------------------------------------------------------
    logic [7:0]  m_prev, m_pend, m_mask, m_edge, m_irq;
    logic [31:0] m_dout;

    function automatic logic [31:0] lowest_set(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 32'hFF;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_pend = 0; m_mask = 0; m_edge = 0; m_irq = 0; m_dout = 0;
    endtask

    task automatic model_edge();
        logic [7:0]  cause, pnext;
        logic [31:0] word, rd;
        logic        hit, ack_b, rise_b;
        cause = m_pend & m_mask;
        hit   = sel_in && (addr_in >= BASE) && (addr_in <= BASE + 32'hFF);
        word  = (addr_in - BASE) & ~32'h3;
        rd    = 0;
        if (hit) begin
            if (word == 32'h00)      rd = {24'h0, cause};
            else if (word == 32'h10) rd = {24'h0, m_mask};
            else if (word == 32'h20) rd = {24'h0, irq_src_in};
            else if (word == 32'h30) rd = {24'h0, m_edge};
            else if (word == 32'h50) rd = lowest_set(cause);
        end
        for (int i = 0; i < 8; i++) begin
            ack_b  = hit && wr_in && (word == 32'h40) && data_in[i];
            rise_b = irq_src_in[i] && !m_prev[i];
            if (m_edge[i]) pnext[i] = (m_pend[i] && !ack_b) || rise_b;
            else           pnext[i] = irq_src_in[i];
        end
        if (hit && wr_in && word == 32'h10) m_mask = data_in[7:0];
        if (hit && wr_in && word == 32'h30) m_edge = data_in[7:0];
        m_dout = rd;
        m_irq  = cause;
        m_pend = pnext;
        m_prev = irq_src_in;
    endtask

    task automatic drive(input logic [7:0] src, input logic sel, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        irq_src_in = src; sel_in = sel; wr_in = wr; addr_in = addr; data_in = data;
    endtask

    // Advance one edge, update the model, then sample 1 time unit later.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0]  src;
        logic        sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_dout;
        logic [7:0]  exp_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic [7:0] src, input logic sel, input logic wr,
                                 input logic [31:0] off, input logic [31:0] data,
                                 input logic [31:0] ed, input logic [7:0] ei);
        vec_t t;
        t.src = src; t.sel = sel; t.wr = wr; t.addr = sel ? BASE + off : 32'h0;
        t.data = data; t.exp_dout = ed; t.exp_irq = ei;
        return t;
    endfunction

    logic [31:0] offs [10] = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50,
                               32'h80, 32'h100, 32'h13, 32'h52};

    initial begin
        logic [7:0] rsrc;
        // Reset: register reads all zero, ID none.
        tbl.push_back(mkv(8'h00, 1, 0, 32'h00, 0, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h10, 0, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h20, 0, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h30, 0, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h40, 0, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h50, 0, 32'hFF, 8'h00));
        // Edge mode pulse on src[2], ACK.
        tbl.push_back(mkv(8'h00, 1, 1, 32'h30, 32'hFFFFFFFF, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 1, 32'h10, 32'h04, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h30, 0, 32'hFF, 8'h00));
        tbl.push_back(mkv(8'h04, 0, 0, 32'h00, 0, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h00, 0, 32'h04, 8'h04));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h50, 0, 32'h02, 8'h04));
        tbl.push_back(mkv(8'h00, 1, 1, 32'h40, 32'h04, 32'h00, 8'h04));
        tbl.push_back(mkv(8'h00, 0, 0, 32'h00, 0, 32'h00, 8'h00));
        // Level mode on src[0]; ACK ignored.
        tbl.push_back(mkv(8'h00, 1, 1, 32'h30, 32'h00, 32'hFF, 8'h00));
        tbl.push_back(mkv(8'h01, 1, 1, 32'h10, 32'h01, 32'h04, 8'h00));
        tbl.push_back(mkv(8'h01, 1, 0, 32'h00, 0, 32'h01, 8'h01));
        tbl.push_back(mkv(8'h01, 1, 1, 32'h40, 32'h01, 32'h00, 8'h01));
        tbl.push_back(mkv(8'h01, 1, 0, 32'h00, 0, 32'h01, 8'h01));
        tbl.push_back(mkv(8'h00, 0, 0, 32'h00, 0, 32'h00, 8'h01));
        tbl.push_back(mkv(8'h00, 0, 0, 32'h00, 0, 32'h00, 8'h00));
        // Edge and ACK on src[1] in the same cycle: set wins.
        tbl.push_back(mkv(8'h00, 1, 1, 32'h30, 32'h02, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 1, 32'h10, 32'h02, 32'h01, 8'h00));
        tbl.push_back(mkv(8'h02, 1, 1, 32'h40, 32'h02, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h02, 1, 0, 32'h00, 0, 32'h02, 8'h02));
        tbl.push_back(mkv(8'h00, 1, 1, 32'h40, 32'h02, 32'h00, 8'h02));
        tbl.push_back(mkv(8'h00, 0, 0, 32'h00, 0, 32'h00, 8'h00));
        // Masked sources latch, appear after unmask.
        tbl.push_back(mkv(8'h00, 1, 1, 32'h10, 32'h00, 32'h02, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 1, 32'h30, 32'hFF, 32'h02, 8'h00));
        tbl.push_back(mkv(8'h28, 0, 0, 32'h00, 0, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h00, 0, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h28, 1, 0, 32'h20, 0, 32'h28, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 1, 32'h10, 32'h28, 32'h00, 8'h00));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h50, 0, 32'h03, 8'h28));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h80, 0, 32'h00, 8'h28));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h100, 0, 32'h00, 8'h28));
        tbl.push_back(mkv(8'h00, 1, 0, 32'h00, 0, 32'h28, 8'h28));

        reset = 1'b0;
        drive(8'h00, 0, 0, 32'h0, 32'h0);
        model_reset();
        #12;
        check("reset data_out", data_out, 32'h0);
        check("reset irq_out", {24'h0, irq_out}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].src, tbl[i].sel, tbl[i].wr, tbl[i].addr, tbl[i].data);
            tick();
            check($sformatf("tbl%0d data_out", i), data_out, tbl[i].exp_dout);
            check($sformatf("tbl%0d irq_out", i), {24'h0, irq_out}, {24'h0, tbl[i].exp_irq});
            check($sformatf("tbl%0d irq_any", i), {31'h0, irq_any_out},
                  {31'h0, |tbl[i].exp_irq});
        end

        // Asynchronous reset mid-operation clears outputs without a clock edge.
        drive(8'h00, 0, 0, 32'h0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("async rst data_out", data_out, 32'h0);
        check("async rst irq_out", {24'h0, irq_out}, 32'h0);
        check("async rst irq_any", {31'h0, irq_any_out}, 32'h0);
        model_reset();
        @(posedge clock);
        #1;
        check("held rst irq_any", {31'h0, irq_any_out}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

`ifndef PE_IRQ_TIMER_EN
        drive(8'h00, 1, 0, BASE + 32'h60, 32'h0);
        tick();
        check("cnt absent", data_out, 32'h0);
        drive(8'h00, 1, 0, BASE + 32'h70, 32'h0);
        tick();
        check("cmp absent", data_out, 32'h0);
`endif

        // Randomized traffic against the model.
        rsrc = 8'h00;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) rsrc = rsrc ^ (8'($urandom) & 8'($urandom));
            drive(rsrc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  BASE + offs[$urandom_range(0, 9)], $urandom);
            tick();
            check($sformatf("rnd%0d data_out", c), data_out, m_dout);
            check($sformatf("rnd%0d irq_out", c), {24'h0, irq_out}, {24'h0, m_irq});
            check($sformatf("rnd%0d irq_any", c), {31'h0, irq_any_out}, {31'h0, |m_irq});
        end

`ifdef PE_IRQ_TIMER_EN
        begin
            logic [31:0] cnt;
            int          seen;
            drive(8'h00, 1, 1, BASE + 32'h10, 32'h80);
            tick();
            drive(8'h00, 1, 1, BASE + 32'h40, 32'h80);
            tick();
            drive(8'h00, 1, 0, BASE + 32'h60, 32'h0);
            tick();
            cnt = data_out;
            drive(8'h00, 1, 1, BASE + 32'h70, cnt + 32'd10);
            tick();
            drive(8'h00, 0, 0, 32'h0, 32'h0);
            seen = 0;
            for (int c = 0; c < 40 && seen == 0; c++) begin
                tick();
                if (irq_out[7]) seen = c + 1;
            end
            check("timer fired", {31'h0, seen != 0}, 32'h1);
            drive(8'h00, 1, 1, BASE + 32'h40, 32'h80);
            tick();
            drive(8'h00, 0, 0, 32'h0, 32'h0);
            tick();
            tick();
            seen = 0;
            for (int c = 0; c < 30; c++) begin
                tick();
                if (irq_out[7]) seen = 1;
            end
            check("timer no retrigger", {31'h0, seen == 1}, 32'h0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
